uart_fifo_periph: RTL and testbench

Memory-mapped UART peripheral for the single-cycle RISC-V SoC, sitting behind the peripheral hub alongside GPIO and data memory. Generalises the existing fixed 8N1 UART: configurable data width, parity and stop bits, a runtime baud divisor, TX/RX FIFOs of parameterised depth, sticky error flags and an interrupt output. The CPU polls STATUS or takes `irq`; no per-byte `sendTx` strobe is needed.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_fifo_periph_if.sv | 11 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/uart_fifo_periph.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_fifo_periph.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART peripheral: register map, parity codes,
// STATUS/CTRL bit positions and the TX/RX state encodings.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_DIV    = 2'd3;

  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_FULL  = 3;
  localparam int ST_TX_BUSY  = 4;
  localparam int ST_RX_OVR   = 5;
  localparam int ST_PAR_ERR  = 6;
  localparam int ST_FRM_ERR  = 7;
  localparam int ST_TX_OVF   = 8;

  localparam int CTRL_STOP2 = 2;
  localparam int CTRL_RX_IE = 3;
  localparam int CTRL_TX_IE = 4;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_periph_if.sv
// Register-bus port between the peripheral hub (master) and the UART (slave).
interface uart_fifo_periph_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, we, addr, wdata, input rdata);
  modport slave  (input sel, we, addr, wdata, output rdata);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             push_ok, pop_ok;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART with programmable framing, runtime baud divisor,
// TX/RX FIFOs, sticky error flags and a level interrupt.
module uart_fifo_periph
  import uart_pkg::*;
#(
  parameter int          DATA_BITS  = 8,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_fifo_periph_if.slave        bus,
  input  logic                     rx,
  output logic                     tx,
  output logic                     irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd4) ? 16'd4 : d;
  endfunction

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic [4:0]  ctrl;
  logic [15:0] div;
  logic        rx_ovr, par_err, frm_err, tx_ovf;
  logic        wr, rd, clr, par_on, par_odd;
  logic [31:0] status;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_BITS-1:0] tx_head;
  logic [CW-1:0]        tx_count;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] rx_head;
  logic [CW-1:0]        rx_count;
  logic                 par_set, frm_set;

  assign wr      = bus.sel & bus.we;
  assign rd      = bus.sel & ~bus.we;
  assign clr     = wr && (bus.addr == ADDR_STATUS);
  assign tx_push = wr && (bus.addr == ADDR_DATA);
  assign rx_pop  = rd && (bus.addr == ADDR_DATA) && !rx_empty;
  assign par_on  = (ctrl[1:0] == PAR_EVEN) || (ctrl[1:0] == PAR_ODD);
  assign par_odd = (ctrl[1:0] == PAR_ODD);

  // TX state machine
  tx_state_t            tx_state, tx_next;
  logic [15:0]          tx_cnt, tx_div;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par, tx_par_en, tx_stop2, tx_load, tx_tick, tx_last;

  assign tx_tick = (tx_cnt == tx_div - 16'd1);
  assign tx_last = (tx_bit == 4'(DATA_BITS - 1));
  assign tx_pop  = tx_load;

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    case (tx_state)
      TX_IDLE:   tx_load = !tx_empty;
      TX_START:  if (tx_tick) tx_next = TX_DATA;
      TX_DATA:   if (tx_tick && tx_last) tx_next = tx_par_en ? TX_PARITY : TX_STOP1;
      TX_PARITY: if (tx_tick) tx_next = TX_STOP1;
      TX_STOP1:
        if (tx_tick) begin
          if (tx_stop2) begin
            tx_next = TX_STOP2;
          end else begin
            tx_next = TX_IDLE;
            tx_load = !tx_empty;
          end
        end
      TX_STOP2:
        if (tx_tick) begin
          tx_next = TX_IDLE;
          tx_load = !tx_empty;
        end
      default:   tx_next = TX_IDLE;
    endcase
    // Chaining straight into the next START avoids an idle gap between frames.
    if (tx_load) tx_next = TX_START;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_load || tx_tick || tx_state == TX_IDLE) ? '0 : tx_cnt + 16'd1;
      if (tx_load) tx_bit <= '0;
      else if (tx_state == TX_DATA && tx_tick) tx_bit <= tx_bit + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load) begin
      tx_shift  <= tx_head;
      tx_div    <= eff_div(div);
      tx_par_en <= par_on;
      tx_par    <= par_bit(tx_head, par_odd);
      tx_stop2  <= ctrl[CTRL_STOP2];
    end else if (tx_state == TX_DATA && tx_tick) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  always_comb begin
    case (tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shift[0];
      TX_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

  // RX synchroniser and state machine
  rx_state_t            rx_state, rx_next;
  logic                 rx_s1, rx_s2, rx_prev, rx_fall;
  logic [15:0]          rx_cnt, rx_div;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_en, rx_par_odd, rx_par_bad;
  logic                 rx_start, rx_tick, rx_half, rx_last, rx_clr;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == rx_div - 16'd1);
  assign rx_half = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_last = (rx_bit == 4'(DATA_BITS - 1));
  assign rx_clr  = (rx_state == RX_IDLE) || ((rx_state == RX_START_CHK) ? rx_half : rx_tick);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    rx_push  = 1'b0;
    par_set  = 1'b0;
    frm_set  = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rx_fall) begin
          rx_start = 1'b1;
          rx_next  = RX_START_CHK;
        end
      RX_START_CHK: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:      if (rx_tick && rx_last) rx_next = rx_par_en ? RX_PARITY : RX_STOP;
      RX_PARITY:    if (rx_tick) rx_next = RX_STOP;
      RX_STOP:
        if (rx_tick) begin
          rx_push = 1'b1;
          par_set = rx_par_en & rx_par_bad;
          frm_set = ~rx_s2;
          rx_next = RX_IDLE;
        end
      default:      rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_clr ? '0 : rx_cnt + 16'd1;
      if (rx_start) rx_bit <= '0;
      else if (rx_state == RX_DATA && rx_tick) rx_bit <= rx_bit + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_start) begin
      rx_div     <= eff_div(div);
      rx_par_en  <= par_on;
      rx_par_odd <= par_odd;
    end
    if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
    if (rx_state == RX_PARITY && rx_tick) rx_par_bad <= (rx_s2 != par_bit(rx_shift, rx_par_odd));
  end

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .wdata(bus.wdata[DATA_BITS-1:0]),
    .pop(tx_pop), .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .wdata(rx_shift),
    .pop(rx_pop), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Registers and sticky flags; a new error outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl    <= '0;
      div     <= DIV_RESET;
      rx_ovr  <= 1'b0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      tx_ovf  <= 1'b0;
    end else begin
      if (wr && bus.addr == ADDR_CTRL) ctrl <= bus.wdata[4:0];
      if (wr && bus.addr == ADDR_DIV)  div  <= bus.wdata[15:0];
      rx_ovr  <= (rx_ovr  & ~(clr & bus.wdata[ST_RX_OVR]))  | (rx_push && rx_full && !rx_pop);
      par_err <= (par_err & ~(clr & bus.wdata[ST_PAR_ERR])) | par_set;
      frm_err <= (frm_err & ~(clr & bus.wdata[ST_FRM_ERR])) | frm_set;
      tx_ovf  <= (tx_ovf  & ~(clr & bus.wdata[ST_TX_OVF]))  | (tx_push && tx_full && !tx_pop);
    end
  end

  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
    status[ST_RX_OVR]   = rx_ovr;
    status[ST_PAR_ERR]  = par_err;
    status[ST_FRM_ERR]  = frm_err;
    status[ST_TX_OVF]   = tx_ovf;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr)
        ADDR_DATA:   if (!rx_empty) bus.rdata[DATA_BITS-1:0] = rx_head;
        ADDR_STATUS: bus.rdata = status;
        ADDR_CTRL:   bus.rdata[4:0] = ctrl;
        default:     bus.rdata[15:0] = div;
      endcase
    end
  end

  assign irq = (ctrl[CTRL_RX_IE] & ~rx_empty) | (ctrl[CTRL_TX_IE] & tx_empty)
             | rx_ovr | par_err | frm_err | tx_ovf;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed sequence with randomized payloads for uart_fifo_periph, checked
// against a frame-level model of the FIFOs, flags and serial waveform.
module tb_uart_fifo_periph;
  import uart_pkg::*;

  localparam int DEPTH = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b0;
  logic rx_drv = 1'b1;
  logic loop   = 1'b0;
  logic rx, tx, irq;

  uart_fifo_periph_if bus();

  assign rx = loop ? tx : rx_drv;

  uart_fifo_periph #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)) dut (
    .clk(clk), .reset(reset), .bus(bus), .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [7:0] rxq[$];
  int         tx_cnt_m  = 0;
  bit         tx_busy_m = 0;
  bit         ovr_m = 0, par_m = 0, frm_m = 0, txovf_m = 0;
  logic [4:0] ctrl_m = '0;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (tx_cnt_m == DEPTH);
    s[1] = (tx_cnt_m == 0);
    s[2] = (rxq.size() > 0);
    s[3] = (rxq.size() == DEPTH);
    s[4] = tx_busy_m;
    s[5] = ovr_m;
    s[6] = par_m;
    s[7] = frm_m;
    s[8] = txovf_m;
    return s;
  endfunction

  function automatic logic exp_irq();
    return (ctrl_m[3] && rxq.size() > 0) || (ctrl_m[4] && tx_cnt_m == 0)
           || ovr_m || par_m || frm_m || txovf_m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus.sel = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    d = bus.rdata;
    @(posedge clk); #1;
    bus.sel = 1'b0;
  endtask

  task automatic set_ctrl(input logic [4:0] v);
    bus_write(ADDR_CTRL, {27'd0, v});
    ctrl_m = v;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] v;
    bus_read(ADDR_STATUS, v);
    check(tag, v, exp_status());
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, exp_irq()});
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] v, e;
    if (rxq.size() > 0) e = {24'd0, rxq.pop_front()};
    else e = 32'd0;
    bus_read(ADDR_DATA, v);
    check(tag, v, e);
  endtask

  // Sender side of the model: one frame in flight plus FIFO occupancy.
  task automatic send_byte(input logic [7:0] d);
    bus_write(ADDR_DATA, {24'd0, d});
    if (!tx_busy_m) tx_busy_m = 1;
    else if (tx_cnt_m < DEPTH) tx_cnt_m++;
    else txovf_m = 1;
  endtask

  task automatic rx_model(input logic [7:0] d, input bit perr, input bit ferr);
    if (rxq.size() < DEPTH) rxq.push_back(d);
    else ovr_m = 1;
    if (perr) par_m = 1;
    if (ferr) frm_m = 1;
  endtask

  task automatic drive_bit(input logic b, input int div);
    rx_drv = b;
    repeat (div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int div, input bit par_en,
                            input logic par_val, input logic stop);
    @(posedge clk); #1;
    drive_bit(1'b0, div);
    for (int i = 0; i < 8; i++) drive_bit(d[i], div);
    if (par_en) drive_bit(par_val, div);
    drive_bit(stop, div);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [7:0]  b;
    logic [7:0]  lb[4];
    bit          bits[$];
    logic [1:0]  pmode;

    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rdata_unsel", bus.rdata, 32'd0);
    check_status("rst_status");
    bus_read(ADDR_DIV, v);  check("rst_div", v, 32'd434);
    bus_read(ADDR_CTRL, v); check("rst_ctrl", v, 32'd0);

    // TX waveform, 8N1 at DIV=4
    bus_write(ADDR_DIV, 32'd4);
    b = 8'hA5;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    bits.push_back(1'b1);
    bus_write(ADDR_DATA, {24'd0, b});
    @(negedge clk);
    check("tx_latency_idle", {31'd0, tx}, 32'd1);
    foreach (bits[k]) begin
      repeat (4) begin
        @(negedge clk);
        check($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, bits[k]});
      end
    end
    check_status("tx_done_status");

    // Loopback 8N1 with RX interrupt enabled
    loop = 1'b1;
    set_ctrl(5'h08);
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      bus_write(ADDR_DATA, {24'd0, lb[i]});
      rx_model(lb[i], 0, 0);
    end
    repeat (250) @(posedge clk);
    check_status("loop1_status");
    for (int i = 0; i < 4; i++) rd_data($sformatf("loop1_data%0d", i));
    check_status("loop1_drained");

    // Loopback with random parity mode and two stop bits
    pmode = 2'($urandom_range(1, 2));
    set_ctrl({2'b00, 1'b1, pmode});
    for (int i = 0; i < 3; i++) begin
      lb[i] = 8'($urandom);
      bus_write(ADDR_DATA, {24'd0, lb[i]});
      rx_model(lb[i], 0, 0);
    end
    repeat (250) @(posedge clk);
    check_status("loop2_status");
    for (int i = 0; i < 3; i++) rd_data($sformatf("loop2_data%0d", i));
    loop = 1'b0;

    // Even parity, wrong parity bit on the line
    set_ctrl(5'h01);
    bus_write(ADDR_DIV, 32'd8);
    send_frame(8'h07, 8, 1, 1'b0, 1'b1);
    rx_model(8'h07, 1, 0);
    repeat (20) @(posedge clk);
    check_status("par_err_status");
    rd_data("par_err_data");
    bus_write(ADDR_STATUS, 32'h40);
    par_m = 0;
    check_status("par_err_cleared");

    // Framing error: stop bit low
    set_ctrl(5'h00);
    b = 8'($urandom);
    send_frame(b, 8, 0, 1'b0, 1'b0);
    rx_model(b, 0, 1);
    repeat (20) @(posedge clk);
    check_status("frm_err_status");
    rd_data("frm_err_data");
    bus_write(ADDR_STATUS, 32'h80);
    frm_m = 0;
    check_status("frm_err_cleared");

    // RX overrun: five frames into a four-entry FIFO
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_frame(b, 8, 0, 1'b0, 1'b1);
      rx_model(b, 0, 0);
    end
    repeat (20) @(posedge clk);
    check_status("rx_ovr_status");
    for (int i = 0; i < 4; i++) rd_data($sformatf("rx_ovr_data%0d", i));
    rd_data("rx_empty_read");
    bus_write(ADDR_STATUS, 32'h20);
    ovr_m = 0;
    check_status("rx_ovr_cleared");

    // Short low glitch on idle line is rejected
    bus_write(ADDR_DIV, 32'd16);
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_drv = 1'b1;
    repeat (60) @(posedge clk);
    check_status("glitch_status");

    // TX overflow with the transmitter stalled at the slowest divisor
    bus_write(ADDR_DIV, 32'h0000_FFFF);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom));
    check_status("tx_ovf_status");
    @(negedge clk);
    check("tx_ovf_start_bit", {31'd0, tx}, 32'd0);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_irq", {31'd0, irq}, 32'd0);
    #1 reset = 1'b1;
    rxq.delete();
    tx_cnt_m = 0; tx_busy_m = 0;
    ovr_m = 0; par_m = 0; frm_m = 0; txovf_m = 0;
    ctrl_m = '0;
    check_status("midreset_status");
    bus_read(ADDR_DIV, v);  check("midreset_div", v, 32'd434);
    bus_read(ADDR_CTRL, v); check("midreset_ctrl", v, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
